adder_wrapper_selftest: RTL and testbench

Built-in self-test driver and checker for the registered adder wrappers generated alongside each prefix-adder variant. It sits on the far side of a wrapper's port list: it drives `a`/`b`, samples `sum`/`cout` after the wrapper's fixed pipeline latency, compares them against an internal golden add, and reports pass/fail status. One instance per wrapper lets any generated adder be checked in simulation or on silicon without an external vector source.

---
 rtl/adder_selftest_pkg.sv | 46 ++++
 rtl/adder_wrapper_selftest_if.sv | 12 +
 rtl/selftest_delay_line.sv | 34 +++
 rtl/adder_wrapper_selftest.sv | 168 ++++++++++++++++
 tb/tb_adder_wrapper_selftest.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/adder_selftest_pkg.sv
// Shared types and constants for the adder wrapper self-test.
// The LFSR tap table is only consumed when ADDER_SELFTEST_LFSR_EN is defined.
package adder_selftest_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   localparam int ERR_CNT_W = 16;

   // Maximal-length Fibonacci taps, bit (t-1) set for tap t; 0 outside 8..32 bits.
   function automatic logic [31:0] lfsr_taps(input int n);
      case (n)
         8:       return 32'h0000_00B8;
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'h0000_D008;
         17:      return 32'h0001_2000;
         18:      return 32'h0002_0400;
         19:      return 32'h0004_0023;
         20:      return 32'h0009_0000;
         21:      return 32'h0014_0000;
         22:      return 32'h0030_0000;
         23:      return 32'h0042_0000;
         24:      return 32'h00E1_0000;
         25:      return 32'h0120_0000;
         26:      return 32'h0200_0023;
         27:      return 32'h0400_0013;
         28:      return 32'h0900_0000;
         29:      return 32'h1400_0000;
         30:      return 32'h2000_0029;
         31:      return 32'h4800_0000;
         32:      return 32'h8020_0003;
         default: return 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/adder_wrapper_selftest_if.sv
// Operand/result bus between the self-test block (master) and the adder wrapper (slave).
interface adder_wrapper_selftest_if #(
   parameter int WIDTH = 4
) ();
   logic [WIDTH-1:0] a_out;
   logic [WIDTH-1:0] b_out;
   logic [WIDTH-1:0] sum_in;
   logic             cout_in;

   modport master (output a_out, b_out, input sum_in, cout_in);
   modport slave  (input a_out, b_out, output sum_in, cout_in);
endinterface

// File: rtl/selftest_delay_line.sv
// LATENCY-stage pipe carrying a valid bit and a payload; clr drops all valid bits.
module selftest_delay_line #(
   parameter int LATENCY = 2,
   parameter int PW      = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          in_valid,
   input  logic [PW-1:0] in_payload,
   output logic          out_valid,
   output logic [PW-1:0] out_payload
);
   logic [LATENCY-1:0] vld_q;
   logic [PW-1:0]      pay_q [LATENCY];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= in_valid;
         for (int s = 1; s < LATENCY; s++) vld_q[s] <= vld_q[s-1];
      end
   end

   // Payload is only observed alongside a valid bit, so it needs no reset.
   always_ff @(posedge clk) begin
      pay_q[0] <= in_payload;
      for (int s = 1; s < LATENCY; s++) pay_q[s] <= pay_q[s-1];
   end

   assign out_valid   = vld_q[LATENCY-1];
   assign out_payload = pay_q[LATENCY-1];
endmodule

// File: rtl/adder_wrapper_selftest.sv
// BIST driver/checker for a registered adder wrapper: drives operands, compares results LATENCY cycles later.
// Define ADDER_SELFTEST_LFSR_EN to add the pseudo-random (lfsr_mode) run.
//
// state    | meaning
// ST_IDLE  | reset state, operands 0, waiting for start
// ST_RUN   | one vector driven per cycle
// ST_DRAIN | operands held, last LATENCY results still being compared
// ST_DONE  | results final, operands held, start begins a new run
module adder_wrapper_selftest
   import adder_selftest_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  lfsr_mode,
   adder_wrapper_selftest_if.master bus,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_CNT_W-1:0]  err_count,
   output logic [WIDTH-1:0]      fail_a,
   output logic [WIDTH-1:0]      fail_b,
   output logic [WIDTH-1:0]      fail_sum,
   output logic                  fail_cout
);
   localparam int VW = 2 * WIDTH;
   localparam int PW = VW + WIDTH + 1;
   localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_e                 state_q;
   logic [VW-1:0]          vec_q, vec_d;
   logic                   last_vec;
   logic [DW-1:0]          drain_q;
   logic                   busy_q, done_q, pass_q, fail_seen_q;
   logic [ERR_CNT_W-1:0]   err_q;
   logic [WIDTH-1:0]       fail_a_q, fail_b_q, fail_sum_q;
   logic                   fail_cout_q;

   logic                   start_ok, mism, dl_vld;
   logic [WIDTH:0]         gold, dl_gold;
   logic [VW-1:0]          dl_ops;
   logic [PW-1:0]          dl_pay;

   assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
   assign gold     = {1'b0, vec_q[VW-1:WIDTH]} + {1'b0, vec_q[WIDTH-1:0]};

   selftest_delay_line #(.LATENCY(LATENCY), .PW(PW)) u_dline (
      .clk         (clk),
      .rst         (rst),
      .clr         (start_ok),
      .in_valid    (state_q == ST_RUN),
      .in_payload  ({vec_q, gold}),
      .out_valid   (dl_vld),
      .out_payload (dl_pay)
   );

   assign {dl_ops, dl_gold} = dl_pay;
   assign mism = dl_vld && ({bus.cout_in, bus.sum_in} != dl_gold);

`ifdef ADDER_SELFTEST_LFSR_EN
   localparam logic [31:0] TAPS = lfsr_taps(VW);
   logic          lfsr_run_q;
   logic [VW-1:0] lfsr_step;

   assign lfsr_step = {vec_q[VW-2:0], ^(vec_q & TAPS[VW-1:0])};

   // Seeded with all-ones, so the run ends just before the sequence returns to the seed.
   always_comb begin
      vec_d    = vec_q + VW'(1);
      last_vec = &vec_q;
      if (lfsr_run_q) begin
         vec_d    = lfsr_step;
         last_vec = &lfsr_step;
      end
   end
`else
   logic unused_lfsr_mode;
   assign unused_lfsr_mode = lfsr_mode;
   assign vec_d    = vec_q + VW'(1);
   assign last_vec = &vec_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         vec_q       <= '0;
         drain_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_q       <= '0;
         fail_seen_q <= 1'b0;
         fail_a_q    <= '0;
         fail_b_q    <= '0;
         fail_sum_q  <= '0;
         fail_cout_q <= 1'b0;
`ifdef ADDER_SELFTEST_LFSR_EN
         lfsr_run_q  <= 1'b0;
`endif
      end else begin
         if (mism) begin
            if (err_q != '1) err_q <= err_q + ERR_CNT_W'(1);
            if (!fail_seen_q) begin
               fail_seen_q <= 1'b1;
               fail_a_q    <= dl_ops[VW-1:WIDTH];
               fail_b_q    <= dl_ops[WIDTH-1:0];
               fail_sum_q  <= bus.sum_in;
               fail_cout_q <= bus.cout_in;
            end
         end
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q     <= ST_RUN;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  pass_q      <= 1'b0;
                  err_q       <= '0;
                  fail_seen_q <= 1'b0;
                  fail_a_q    <= '0;
                  fail_b_q    <= '0;
                  fail_sum_q  <= '0;
                  fail_cout_q <= 1'b0;
                  vec_q       <= '0;
`ifdef ADDER_SELFTEST_LFSR_EN
                  lfsr_run_q  <= lfsr_mode;
                  if (lfsr_mode) vec_q <= '1;
`endif
               end
            end
            ST_RUN: begin
               if (last_vec) begin
                  state_q <= ST_DRAIN;
                  drain_q <= '0;
               end else begin
                  vec_q <= vec_d;
               end
            end
            ST_DRAIN: begin
               if (drain_q == DW'(LATENCY - 1)) begin
                  // The final compare lands on this same edge, so include it in pass.
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= !((err_q != '0) || mism);
               end else begin
                  drain_q <= drain_q + DW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.a_out = vec_q[VW-1:WIDTH];
   assign bus.b_out = vec_q[WIDTH-1:0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_a    = fail_a_q;
   assign fail_b    = fail_b_q;
   assign fail_sum  = fail_sum_q;
   assign fail_cout = fail_cout_q;
endmodule

// File: tb/tb_adder_wrapper_selftest.sv
// Bench for adder_wrapper_selftest: behavioural wrappers with injectable faults, LATENCY 2 and 3 instances.
module tb_adder_wrapper_selftest;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic lfsr_mode = 1'b0;
   always #5 clk = ~clk;

   adder_wrapper_selftest_if #(.WIDTH(W)) bus2 ();
   adder_wrapper_selftest_if #(.WIDTH(W)) bus3 ();

   logic busy2, done2, pass2, fc2, busy3, done3, pass3, fc3;
   logic [15:0] err2, err3;
   logic [W-1:0] fa2, fb2, fs2, fa3, fb3, fs3;

   adder_wrapper_selftest #(.WIDTH(W), .LATENCY(2)) dut (
      .clk(clk), .rst(rst), .start(start), .lfsr_mode(lfsr_mode), .bus(bus2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .fail_a(fa2), .fail_b(fb2), .fail_sum(fs2), .fail_cout(fc2));

   adder_wrapper_selftest #(.WIDTH(W), .LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .start(start), .lfsr_mode(lfsr_mode), .bus(bus3),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
      .fail_a(fa3), .fail_b(fb3), .fail_sum(fs3), .fail_cout(fc3));

   // mode: 0 correct, 1 cout stuck at 0, 2 extra output register, 3 per-vector xor pattern
   int mode = 0;
   logic [4:0] pat [256];

   function automatic logic [4:0] wrap_f(input logic [3:0] a, input logic [3:0] b);
      logic [4:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (mode == 1) s[4] = 1'b0;
      if (mode == 3) s = s ^ pat[{a, b}];
      return s;
   endfunction

   logic [3:0] ra2, rb2, ra3, rb3;
   logic [4:0] r2a, r2b, s3a, s3b;
   always @(posedge clk) begin
      ra2 <= bus2.a_out; rb2 <= bus2.b_out;
      r2a <= wrap_f(ra2, rb2); r2b <= r2a;
      ra3 <= bus3.a_out; rb3 <= bus3.b_out;
      s3a <= {1'b0, ra3} + {1'b0, rb3}; s3b <= s3a;
   end
   assign {bus2.cout_in, bus2.sum_in} = (mode == 2) ? r2b : r2a;
   assign {bus3.cout_in, bus3.sum_in} = s3b;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic run_test(input int restart_at, input bit lfsr, output int d2, output int d3);
      int k;
      @(negedge clk); start = 1'b1; lfsr_mode = lfsr;
      @(negedge clk); start = 1'b0;
      k = 0; d2 = -1; d3 = -1;
      chk("busy_rise", busy2, 1);
      chk("err_clear_on_start", err2, 0);
      chk("done_clear_on_start", done2, 0);
      chk("fail_a_clear_on_start", fa2, 0);
      while ((d2 < 0 || d3 < 0) && k < 600) begin
         if (done2 && d2 < 0) d2 = k;
         if (done3 && d3 < 0) d3 = k;
         if (k == 0) begin
            chk("vec0_a", bus2.a_out, lfsr ? 15 : 0);
            chk("vec0_b", bus2.b_out, lfsr ? 15 : 0);
         end
         if (!lfsr && k == 17) begin
            chk("vec17_a", bus2.a_out, 1);
            chk("vec17_b", bus2.b_out, 1);
         end
         start = (k == restart_at);
         @(negedge clk); k++;
      end
      start = 1'b0;
   endtask

   typedef struct {
      int mode;
      int restart_at;
      int exp_done;
      int exp_pass;
      int exp_err;   // -1: any nonzero count
      int chk_fail;
      int fa, fb, fs, fc;
   } vec_t;
   vec_t tbl [4];

   initial begin
      #3ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d2, d3, k, exp_err, first, ex_s;
      bit lfsr_flag;
      lfsr_flag = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_busy", busy2, 0);
      chk("rst_done", done2, 0);
      chk("rst_pass", pass2, 0);
      chk("rst_err", err2, 0);
      chk("rst_a", bus2.a_out, 0);
      chk("rst_b", bus2.b_out, 0);
      chk("rst_fail", {fa2, fb2, fs2, fc2}, 0);
      rst = 1'b0;

      tbl[0] = '{0, -1, 258, 1, 0,   1, 0, 0, 0, 0};
      tbl[1] = '{1, -1, 258, 0, 120, 1, 1, 15, 0, 0};
      tbl[2] = '{2, -1, 258, 0, -1,  0, 0, 0, 0, 0};
      tbl[3] = '{0, 50, 258, 1, 0,   1, 0, 0, 0, 0};

      for (int i = 0; i < 4; i++) begin
         mode = tbl[i].mode;
         run_test(tbl[i].restart_at, lfsr_flag, d2, d3);
         chk($sformatf("row%0d_done_cycle", i), d2, tbl[i].exp_done);
         chk($sformatf("row%0d_lat3_done_cycle", i), d3, 259);
         chk($sformatf("row%0d_lat3_pass", i), pass3, 1);
         chk($sformatf("row%0d_pass", i), pass2, tbl[i].exp_pass);
         if (tbl[i].exp_err < 0) chk($sformatf("row%0d_err_nonzero", i), int'(err2 != 0), 1);
         else chk($sformatf("row%0d_err", i), err2, tbl[i].exp_err);
         if (tbl[i].chk_fail != 0) begin
            chk($sformatf("row%0d_fail_a", i), fa2, tbl[i].fa);
            chk($sformatf("row%0d_fail_b", i), fb2, tbl[i].fb);
            chk($sformatf("row%0d_fail_sum", i), fs2, tbl[i].fs);
            chk($sformatf("row%0d_fail_cout", i), fc2, tbl[i].fc);
         end
         chk($sformatf("row%0d_a_held", i), bus2.a_out, 15);
         chk($sformatf("row%0d_b_held", i), bus2.b_out, 15);
      end

      // Random fault maps against a vector-order reference model.
      for (int r = 0; r < 3; r++) begin
         for (int v = 0; v < 256; v++)
            pat[v] = ($urandom_range(0, 11) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         exp_err = 0; first = -1; ex_s = 0;
         for (int v = 0; v < 256; v++) begin
            if (pat[v] != 0) begin
               exp_err++;
               if (first < 0) begin
                  first = v;
                  ex_s = ((v / 16) + (v % 16)) ^ int'(pat[v]);
               end
            end
         end
         mode = 3;
         run_test(-1, 1'b0, d2, d3);
         chk($sformatf("rnd%0d_done_cycle", r), d2, 258);
         chk($sformatf("rnd%0d_err", r), err2, exp_err);
         chk($sformatf("rnd%0d_pass", r), pass2, (exp_err == 0) ? 1 : 0);
         chk($sformatf("rnd%0d_fail_a", r), fa2, (first < 0) ? 0 : first / 16);
         chk($sformatf("rnd%0d_fail_b", r), fb2, (first < 0) ? 0 : first % 16);
         chk($sformatf("rnd%0d_fail_sum", r), fs2, (first < 0) ? 0 : ex_s % 16);
         chk($sformatf("rnd%0d_fail_cout", r), fc2, (first < 0) ? 0 : ex_s / 16);
      end

      // Reset in the middle of a faulty run, then a clean run.
      mode = 1;
      @(negedge clk); start = 1'b1; lfsr_mode = 1'b0;
      @(negedge clk); start = 1'b0;
      k = 0;
      while (k < 99) begin @(negedge clk); k++; end
      exp_err = 0;
      for (int v = 0; v <= 96; v++) if ((v / 16) + (v % 16) > 15) exp_err++;
      chk("midrun_err_before_rst", err2, exp_err);
      rst = 1'b1;
      @(negedge clk);
      chk("midrun_rst_busy", busy2, 0);
      chk("midrun_rst_done_pass", {done2, pass2}, 0);
      chk("midrun_rst_err", err2, 0);
      chk("midrun_rst_ab", {bus2.a_out, bus2.b_out}, 0);
      chk("midrun_rst_fail", {fa2, fb2, fs2, fc2}, 0);
      chk("midrun_rst_lat3_busy", busy3, 0);
      rst = 1'b0;
      mode = 0;
      run_test(-1, 1'b0, d2, d3);
      chk("after_rst_done_cycle", d2, 258);
      chk("after_rst_pass", pass2, 1);
      chk("after_rst_err", err2, 0);

`ifdef ADDER_SELFTEST_LFSR_EN
      mode = 0;
      run_test(-1, 1'b1, d2, d3);
      chk("lfsr_done_cycle", d2, 257);
      chk("lfsr_lat3_done_cycle", d3, 258);
      chk("lfsr_pass", pass2, 1);
      chk("lfsr_err", err2, 0);
      lfsr_mode = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
